bcd_calc_sequencer: RTL and testbench

- Digit-serial controller that runs the arithmetic step after the operator has entered both 4-digit BCD operands.
- Latches operands A and B from the operand register bank, validates them, and performs BCD add or subtract one digit per slow_clk cycle.
- Writes the result back into the operand bank through its set/setVal load port.
- Drives the end_obl "calculation finished" flag consumed by the keypad state machine.

---
 rtl/bcd_calc_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_bcd_calc_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_calc_sequencer.sv
// Digit-serial BCD add/subtract sequencer.
// Latches two DIGITS-wide BCD operands, checks every digit and computes A+B or
// A-B one digit per clock, starting with the least significant digit. When
// A-B would be negative, B-A is computed on a second pass and neg is raised.
// The magnitude is returned on setVal together with a one-cycle set strobe.
module bcd_calc_sequencer #(
    parameter int DIGITS     = 4,
    parameter bit WRITE_BACK = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                op,
    input  logic [4*DIGITS-1:0] a_bcd,
    input  logic [4*DIGITS-1:0] b_bcd,
    output logic                end_obl,
    output logic                set,
    output logic [4*DIGITS-1:0] setVal,
    output logic                neg,
    output logic                ovf,
    output logic                err
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_CALC  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          state_r;
    logic [W-1:0]    x_r;
    logic [W-1:0]    y_r;
    logic [W-1:0]    work_r;
    logic            op_r;
    logic [IW-1:0]   idx_r;
    logic            cy_r;
    logic            swapped_r;

    logic [3:0]      x_dig_s;
    logic [3:0]      y_dig_s;
    logic [4:0]      x5_s;
    logic [4:0]      sum_s;
    logic [4:0]      sub_s;
    logic [4:0]      t_s;
    logic [3:0]      dig_s;
    logic            cout_s;
    logic            last_s;

    // True when every 4-bit digit of v is a legal BCD value (0..9).
    function automatic logic digits_ok(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    // One BCD digit of add or subtract, with decimal carry/borrow correction.
    always_comb begin
        x_dig_s = x_r[{idx_r, 2'b00} +: 4];
        y_dig_s = y_r[{idx_r, 2'b00} +: 4];
        x5_s    = {1'b0, x_dig_s};
        sum_s   = x5_s + {1'b0, y_dig_s} + {4'b0000, cy_r};
        sub_s   = {1'b0, y_dig_s} + {4'b0000, cy_r};
        t_s     = 5'd0;
        cout_s  = 1'b0;
        if (op_r == 1'b0) begin
            if (sum_s > 5'd9) begin
                t_s    = sum_s - 5'd10;
                cout_s = 1'b1;
            end else begin
                t_s    = sum_s;
                cout_s = 1'b0;
            end
        end else begin
            if (x5_s >= sub_s) begin
                t_s    = x5_s - sub_s;
                cout_s = 1'b0;
            end else begin
                t_s    = x5_s + 5'd10 - sub_s;
                cout_s = 1'b1;
            end
        end
        dig_s  = t_s[3:0];
        last_s = (idx_r == IW'(DIGITS - 1));
    end

    // Sequencer state, operand/working registers and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= S_IDLE;
            x_r       <= '0;
            y_r       <= '0;
            work_r    <= '0;
            op_r      <= 1'b0;
            idx_r     <= '0;
            cy_r      <= 1'b0;
            swapped_r <= 1'b0;
            end_obl   <= 1'b1;
            set       <= 1'b0;
            setVal    <= '0;
            neg       <= 1'b0;
            ovf       <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        x_r       <= a_bcd;
                        y_r       <= b_bcd;
                        op_r      <= op;
                        neg       <= 1'b0;
                        ovf       <= 1'b0;
                        err       <= 1'b0;
                        swapped_r <= 1'b0;
                        end_obl   <= 1'b0;
                        state_r   <= S_CHECK;
                    end else begin
                        state_r   <= S_IDLE;
                    end
                end
                S_CHECK: begin
                    idx_r  <= '0;
                    cy_r   <= 1'b0;
                    work_r <= '0;
                    // Bad operands pass through the WRITE slot with the write
                    // suppressed, so end_obl rises three cycles after start.
                    if (!digits_ok(x_r) || !digits_ok(y_r)) begin
                        err     <= 1'b1;
                        state_r <= S_WRITE;
                    end else begin
                        state_r <= S_CALC;
                    end
                end
                S_CALC: begin
                    work_r[{idx_r, 2'b00} +: 4] <= dig_s;
                    cy_r <= cout_s;
                    if (last_s) begin
                        if (op_r == 1'b0) begin
                            ovf     <= cout_s;
                            state_r <= S_WRITE;
                        end else if (cout_s && !swapped_r) begin
                            // A<B: recompute as B-A and mark the result negative.
                            neg       <= 1'b1;
                            swapped_r <= 1'b1;
                            x_r       <= y_r;
                            y_r       <= x_r;
                            idx_r     <= '0;
                            cy_r      <= 1'b0;
                            state_r   <= S_CALC;
                        end else begin
                            state_r <= S_WRITE;
                        end
                    end else begin
                        idx_r <= idx_r + 1'b1;
                    end
                end
                S_WRITE: begin
                    if (!err) begin
                        setVal <= work_r;
                        set    <= WRITE_BACK;
                    end else begin
                        set    <= 1'b0;
                    end
                    state_r <= S_DONE;
                end
                S_DONE: begin
                    set     <= 1'b0;
                    end_obl <= 1'b1;
                    state_r <= S_IDLE;
                end
                default: begin
                    set     <= 1'b0;
                    end_obl <= 1'b1;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_calc_sequencer.sv
// Self-checking bench for bcd_calc_sequencer (DIGITS=4, WRITE_BACK=1).
// Expected results come from integer arithmetic on the decoded operands.
module tb_bcd_calc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [15:0] a_bcd = 16'h0000;
    logic [15:0] b_bcd = 16'h0000;
    logic        end_obl;
    logic        set;
    logic [15:0] setVal;
    logic        neg;
    logic        ovf;
    logic        err;

    int compared = 0;
    int mismatched = 0;
    logic [15:0] model_val = 16'h0000;

    bcd_calc_sequencer #(.DIGITS(4), .WRITE_BACK(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .a_bcd(a_bcd), .b_bcd(b_bcd),
        .end_obl(end_obl), .set(set), .setVal(setVal),
        .neg(neg), .ovf(ovf), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic bit bcd_ok(input logic [15:0] v);
        logic [15:0] t;
        t = v;
        for (int i = 0; i < 4; i++) begin
            if (t[4*i +: 4] > 4'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int bcd2int(input logic [15:0] v);
        int r;
        r = 0;
        for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input int n);
        logic [15:0] r;
        int m;
        m = n;
        r = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic logic [15:0] rand_bcd();
        return int2bcd(int'($urandom_range(0, 9999)));
    endfunction

    // One operation: start sampled at edge 0; optional busy start pulse over edge inj.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic o, input int inj);
        int ai, bi, r;
        logic [15:0] exp_val;
        int exp_set, exp_end, exp_neg, exp_ovf, exp_err;
        int set_cyc, end_cyc, pulses;
        logic [15:0] val_at_set;
        ai = bcd2int(a);
        bi = bcd2int(b);
        exp_neg = 0; exp_ovf = 0; exp_err = 0;
        if (!bcd_ok(a) || !bcd_ok(b)) begin
            exp_err = 1; exp_set = -1; exp_end = 3; exp_val = model_val;
        end else if (!o) begin
            r = ai + bi;
            exp_ovf = (r > 9999) ? 1 : 0;
            exp_val = int2bcd(r % 10000); exp_set = 6; exp_end = 7;
        end else if (ai >= bi) begin
            exp_val = int2bcd(ai - bi); exp_set = 6; exp_end = 7;
        end else begin
            exp_val = int2bcd(bi - ai); exp_neg = 1; exp_set = 10; exp_end = 11;
        end
        if (exp_err == 0) model_val = exp_val;

        a_bcd = a; b_bcd = b; op = o; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a_bcd = rand_bcd(); b_bcd = rand_bcd(); op = ~o;
        set_cyc = -1; end_cyc = -1; pulses = 0; val_at_set = 16'h0000;
        for (int cyc = 1; cyc <= 20 && end_cyc < 0; cyc++) begin
            @(posedge clk); #1;
            if (cyc == inj - 1) start = 1'b1;
            if (cyc == inj) start = 1'b0;
            if (set === 1'b1) begin
                pulses++;
                if (set_cyc < 0) begin
                    set_cyc = cyc;
                    val_at_set = setVal;
                end
            end
            if (end_obl === 1'b1) end_cyc = cyc;
        end
        start = 1'b0;
        check({tag, ".end_cycle"}, end_cyc, exp_end);
        check({tag, ".set_cycle"}, set_cyc, exp_set);
        check({tag, ".set_pulses"}, pulses, (exp_err != 0) ? 0 : 1);
        if (exp_err == 0) check({tag, ".val_at_set"}, int'(val_at_set), int'(exp_val));
        check({tag, ".setVal"}, int'(setVal), int'(exp_val));
        check({tag, ".neg"}, int'(neg), exp_neg);
        check({tag, ".ovf"}, int'(ovf), exp_ovf);
        check({tag, ".err"}, int'(err), exp_err);
    endtask

    initial begin
        int end_seen;
        logic [15:0] ra, rb;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_low.end_obl", int'(end_obl), 1);
        check("rst_low.set", int'(set), 0);
        check("rst_low.setVal", int'(setVal), 0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("idle.end_obl", int'(end_obl), 1);
        check("idle.set", int'(set), 0);
        check("idle.flags", int'({neg, ovf, err}), 0);
        check("idle.setVal", int'(setVal), 0);

        // Directed cases
        run_op("add_plain", 16'h0123, 16'h0456, 1'b0, 0);
        run_op("add_ovf",   16'h9999, 16'h0001, 1'b0, 0);
        run_op("sub_pos",   16'h0100, 16'h0025, 1'b1, 0);
        run_op("sub_neg",   16'h0025, 16'h0100, 1'b1, 0);
        run_op("sub_zero",  16'h4321, 16'h4321, 1'b1, 0);
        run_op("bad_digit", 16'h00A1, 16'h0001, 1'b0, 0);
        run_op("busy_add",  16'h0808, 16'h0293, 1'b0, 3);
        run_op("busy_swap", 16'h0001, 16'h9000, 1'b1, 8);

        // Reset pulsed in cycle 4 aborts the operation
        a_bcd = 16'h1111; b_bcd = 16'h2222; op = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("abort.end_obl", int'(end_obl), 1);
        check("abort.set", int'(set), 0);
        check("abort.setVal", int'(setVal), 0);
        @(negedge clk); rst = 1'b1;
        model_val = 16'h0000;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (set !== 1'b0) check("abort.no_set", int'(set), 0);
        end
        check("abort.still_idle", int'(end_obl), 1);
        run_op("after_abort", 16'h0450, 16'h0550, 1'b0, 0);

        // start held high through DONE restarts only once IDLE is re-entered
        a_bcd = 16'h0011; b_bcd = 16'h0022; op = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        repeat (6) @(posedge clk);
        #1;
        check("hold.set_c6", int'(set), 1);
        @(posedge clk); #1;
        check("hold.end_c7", int'(end_obl), 1);
        @(posedge clk); #1;
        check("hold.restart_c8", int'(end_obl), 0);
        start = 1'b0;
        end_seen = 0;
        for (int i = 0; i < 20 && end_seen == 0; i++) begin
            @(posedge clk); #1;
            if (end_obl === 1'b1) end_seen = 1;
        end
        check("hold.second_done", end_seen, 1);
        check("hold.setVal", int'(setVal), 16'h0033);
        model_val = 16'h0033;

        // Randomized operations against the arithmetic model
        for (int k = 0; k < 24; k++) begin
            ra = rand_bcd();
            rb = rand_bcd();
            if ($urandom_range(0, 7) == 0) ra[4*$urandom_range(0, 3) +: 4] = 4'(10 + $urandom_range(0, 5));
            run_op($sformatf("rand%0d", k), ra, rb, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 9)) : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
